// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths and the write-back request type for the
//               register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    localparam int WB_REQ_W = $bits(wb_req_t);

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_fifo
// Description : Synchronous power-of-two FIFO of write-back requests with
//               asynchronous reset; push when full and pop when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_push,
    input  logic [WB_REQ_W-1:0]              i_push_data,
    input  logic                             i_pop,
    output logic [WB_REQ_W-1:0]              o_head,
    output logic [$clog2(DEPTH+1)-1:0]       o_count,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);

    wb_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the pipeline
//               write-back path and buffered MDU results. Define
//               WB_ARB_FAIRNESS_EN to build the starvation-driven forced grant.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int MDU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pipe_valid,
    input  logic [4:0]           i_pipe_rd,
    input  logic [63:0]          i_pipe_data,
    output logic                 o_pipe_stall,
    input  logic                 i_mdu_valid,
    input  logic [4:0]           i_mdu_rd,
    input  logic [63:0]          i_mdu_data,
    output logic                 o_mdu_ready,
    output logic [4:0]           o_rd_index,
    output logic [63:0]          o_rd_data,
    output logic                 o_rd_we
);

    localparam int CNT_W = $clog2(MDU_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_fifo_depth = CNT_W'(MDU_FIFO_DEPTH);

    logic                   w_pipe_req;
    logic                   w_fifo_req;
    logic                   w_force;
    logic                   w_grant_f;
    logic                   w_grant_p;
    logic                   w_push;

    logic [WB_REQ_W-1:0]    w_push_bits;
    logic [WB_REQ_W-1:0]    w_head_bits;
    wb_req_t                w_head;
    logic [CNT_W-1:0]       w_fifo_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_unused_full;

    logic                   r_rd_we;
    logic [4:0]             r_rd_index;
    logic [63:0]            r_rd_data;

    assign w_pipe_req  = i_pipe_valid && (i_pipe_rd != 5'd0);
    assign w_fifo_req  = !w_fifo_empty;
    assign o_mdu_ready = (w_fifo_count < c_fifo_depth);

    // Results targeting x0 complete the handshake but are never stored.
    assign w_push      = i_mdu_valid && o_mdu_ready && (i_mdu_rd != 5'd0);
    assign w_push_bits = {i_mdu_rd, i_mdu_data};
    assign w_head      = w_head_bits;
    assign w_unused_full = w_fifo_full;

    wb_result_fifo #(
        .DEPTH       (MDU_FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data (w_push_bits),
        .i_pop       (w_grant_f),
        .o_head      (w_head_bits),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

`ifdef WB_ARB_FAIRNESS_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] c_starve_max = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] c_starve_one = SC_W'(1);

    logic [SC_W-1:0] r_starve_cnt;

    assign w_force      = w_fifo_req && (r_starve_cnt == c_starve_max);
    assign o_pipe_stall = w_force && w_pipe_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (!w_fifo_req || w_grant_f) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + c_starve_one;
        end
    end
`else
    assign w_force      = 1'b0;
    assign o_pipe_stall = 1'b0;
`endif

    assign w_grant_f = w_fifo_req && (!w_pipe_req || w_force);
    assign w_grant_p = w_pipe_req && !w_grant_f;

    // Index and data hold across idle cycles; only the enable drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_we    <= 1'b0;
            r_rd_index <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_we <= w_grant_f || w_grant_p;
            if (w_grant_f) begin
                r_rd_index <= w_head.rd;
                r_rd_data  <= w_head.data;
            end else if (w_grant_p) begin
                r_rd_index <= i_pipe_rd;
                r_rd_data  <= i_pipe_data;
            end
        end
    end

    assign o_rd_we    = r_rd_we;
    assign o_rd_index = r_rd_index;
    assign o_rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter against a queue-based
//               reference model; honours WB_ARB_FAIRNESS_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [63:0] mdu_data;
    logic        o_pipe_stall;
    logic        o_mdu_ready;
    logic [4:0]  o_rd_index;
    logic [63:0] o_rd_data;
    logic        o_rd_we;

    wb_port_arbiter #(
        .MDU_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pipe_valid (pipe_valid),
        .i_pipe_rd    (pipe_rd),
        .i_pipe_data  (pipe_data),
        .o_pipe_stall (o_pipe_stall),
        .i_mdu_valid  (mdu_valid),
        .i_mdu_rd     (mdu_rd),
        .i_mdu_data   (mdu_data),
        .o_mdu_ready  (o_mdu_ready),
        .o_rd_index   (o_rd_index),
        .o_rd_data    (o_rd_data),
        .o_rd_we      (o_rd_we)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [4:0]  q_rd[$];
    logic [63:0] q_data[$];
    int          starve;
    logic        exp_we;
    logic [4:0]  exp_idx;
    logic [63:0] exp_data;
    bit          last_stall;
    bit          last_acc;
    bit          obs_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_rd.delete();
        q_data.delete();
        starve     = 0;
        exp_we     = 1'b0;
        exp_idx    = '0;
        exp_data   = '0;
        last_stall = 1'b0;
        last_acc   = 1'b0;
    endtask

    // Inputs are driven by the caller one time unit after an edge.
    task automatic do_cycle();
        bit preq, f, frc, gf, gp, acc;
        #1;
        preq = pipe_valid && (pipe_rd != 5'd0);
        f    = (q_rd.size() != 0);
        frc  = FAIR && (starve == LIMIT) && f;
        gf   = f && (!preq || frc);
        gp   = preq && !gf;
        chk("pipe_stall", o_pipe_stall, frc && preq);
        chk("mdu_ready", o_mdu_ready, q_rd.size() < DEPTH);
        obs_stall = o_pipe_stall;
        acc = mdu_valid && (q_rd.size() < DEPTH);
        @(posedge i_clk);
        if (gf) begin
            exp_idx  = q_rd.pop_front();
            exp_data = q_data.pop_front();
        end else if (gp) begin
            exp_idx  = pipe_rd;
            exp_data = pipe_data;
        end
        exp_we = gf || gp;
        if (acc && mdu_rd != 5'd0) begin
            q_rd.push_back(mdu_rd);
            q_data.push_back(mdu_data);
        end
        if (!f || gf) starve = 0;
        else if (starve < LIMIT) starve++;
        last_stall = frc && preq;
        last_acc   = acc;
        #1;
        chk("rd_we", o_rd_we, exp_we);
        chk("rd_index", o_rd_index, exp_idx);
        chk("rd_data", o_rd_data, exp_data);
    endtask

    task automatic idle_inputs();
        pipe_valid = 1'b0;
        pipe_rd    = '0;
        pipe_data  = '0;
        mdu_valid  = 1'b0;
        mdu_rd     = '0;
        mdu_data   = '0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_we", o_rd_we, 1'b0);
        chk("rst_index", o_rd_index, 5'd0);
        chk("rst_data", o_rd_data, 64'd0);
        chk("rst_stall", o_pipe_stall, 1'b0);
        chk("rst_ready", o_mdu_ready, 1'b1);
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
    endtask

    initial begin
        int first_stall;
        i_rst = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        do_reset();

        // Pipeline only
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hA5;
        do_cycle();
        chk("pipe_we", o_rd_we, 1'b1);
        chk("pipe_index", o_rd_index, 5'd5);
        chk("pipe_data", o_rd_data, 64'hA5);
        pipe_rd = 5'd0; pipe_data = 64'h77;
        do_cycle();
        chk("pipe_x0_we", o_rd_we, 1'b0);

        // MDU result into a bubble
        idle_inputs();
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 64'h1234;
        do_cycle();
        chk("bubble_accept_we", o_rd_we, 1'b0);
        mdu_valid = 1'b0;
        do_cycle();
        chk("bubble_we", o_rd_we, 1'b1);
        chk("bubble_index", o_rd_index, 5'd7);
        chk("bubble_data", o_rd_data, 64'h1234);
        do_cycle();

        // FIFO full with pipeline busy; third result held, then drained in order
        pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 64'h22;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 64'h1;
        do_cycle();
        mdu_rd = 5'd10; mdu_data = 64'h2;
        do_cycle();
        mdu_rd = 5'd11; mdu_data = 64'h3;
        #1;
        chk("full_ready", o_mdu_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (last_acc) mdu_valid = 1'b0;
            do_cycle();
        end
        pipe_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (last_acc) mdu_valid = 1'b0;
            do_cycle();
        end
        idle_inputs();
        do_cycle();

        // Fairness scenario: pipe busy every cycle, one FIFO entry
        do_reset();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'd100;
        mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 64'hBEEF;
        do_cycle();
        mdu_valid = 1'b0;
        first_stall = 0;
        for (int k = 1; k <= 8; k++) begin
            if (!last_stall) pipe_data = 64'd100 + 64'(k);
            do_cycle();
            if (obs_stall && first_stall == 0) first_stall = k;
        end
        chk("first_stall_cycle", 64'(first_stall), FAIR ? 64'd5 : 64'd0);
        pipe_valid = 1'b0;
        do_cycle();
`ifndef WB_ARB_FAIRNESS_EN
        chk("nofair_bubble_index", o_rd_index, 5'd12);
        chk("nofair_bubble_data", o_rd_data, 64'hBEEF);
`endif
        do_cycle();

        // Reset mid-operation with two FIFO entries
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 64'h44;
        mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 64'hAA;
        do_cycle();
        mdu_rd = 5'd21; mdu_data = 64'hBB;
        do_cycle();
        mdu_valid = 1'b0;
        do_cycle();
        chk("pre_reset_we", o_rd_we, 1'b1);
        #3;
        i_rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_we", o_rd_we, 1'b0);
        chk("async_rst_ready", o_mdu_ready, 1'b1);
        chk("async_rst_index", o_rd_index, 5'd0);
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 4; k++) do_cycle();

        // Randomized traffic with stall and ready handshakes honoured
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                pipe_valid = ($urandom_range(0, 9) < 6);
                pipe_rd    = 5'($urandom_range(0, 31));
                pipe_data  = {$urandom, $urandom};
            end
            if (!(mdu_valid && !last_acc)) begin
                mdu_valid = ($urandom_range(0, 9) < 4);
                mdu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdu_data  = {$urandom, $urandom};
            end
            do_cycle();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) do_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
